// File: rtl/acc_threshold.sv
`timescale 1ns / 1ps
// acc_threshold: in-place binarisation of the Sobel edge image.
// Each word holds four 8-bit pixels (pixel k in bits 8k+7..8k). Every pixel
// is rewritten as 8'hFF if it is >= the threshold latched at start, else 8'h00.
// The number of FF pixels is reported on edge_count.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   addr, en, we        single-port memory request (word address)
//   dataR, dataW        memory read data (one cycle latency) / write data
//   start, threshold    run request (sampled in IDLE) and threshold (latched on start)
//   finish              high while in DONE
//   edge_count          FF pixel count of the last run (saturating)
module acc_threshold #(
    parameter int unsigned BASE_ADDR = 25344,
    parameter int unsigned NUM_WORDS = 25344,
    parameter int unsigned CNT_W     = 17
) (
    input  logic             clk,
    input  logic             reset,
    output logic [15:0]      addr,
    input  logic [31:0]      dataR,
    output logic [31:0]      dataW,
    output logic             en,
    output logic             we,
    input  logic             start,
    input  logic [7:0]       threshold,
    output logic             finish,
    output logic [CNT_W-1:0] edge_count
);

    localparam int unsigned     IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [15:0]     BASE     = 16'(BASE_ADDR);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         thr_q, thr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [31:0]        bin_word;
    logic [2:0]         pop;
    logic [CNT_W:0]     cnt_sum;
    logic [CNT_W-1:0]   cnt_sat;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            thr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            thr_q   <= thr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Per-lane compare of the word currently on dataR
    always_comb begin
        bin_word = '0;
        pop      = '0;
        for (int b = 0; b < 4; b++) begin
            if (dataR[8*b +: 8] >= thr_q) begin
                bin_word[8*b +: 8] = 8'hFF;
                pop                = pop + 3'd1;
            end
        end
    end

    // One extra bit catches the carry so the count sticks at all-ones
    always_comb begin
        cnt_sum = {1'b0, cnt_q} + (CNT_W + 1)'(pop);
        cnt_sat = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        thr_d   = thr_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    thr_d   = threshold;
                    cnt_d   = '0;
                    idx_d   = '0;
                    // The read of word 0 is issued in this cycle
                    state_d = StWrite;
                end
            end
            StRead: begin
                state_d = StWrite;
            end
            StWrite: begin
                cnt_d = cnt_sat;
                if (idx_q == LAST_IDX) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = StRead;
                end
            end
            StDone: begin
                // A held start keeps us here so it cannot retrigger a run
                if (!start) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output logic
    always_comb begin
        en     = 1'b0;
        we     = 1'b0;
        addr   = '0;
        dataW  = '0;
        finish = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    en   = 1'b1;
                    addr = BASE;
                end
            end
            StRead: begin
                en   = 1'b1;
                addr = BASE + 16'(idx_q);
            end
            StWrite: begin
                en    = 1'b1;
                we    = 1'b1;
                addr  = BASE + 16'(idx_q);
                dataW = bin_word;
            end
            StDone: begin
                finish = 1'b1;
            end
            default: begin
                en = 1'b0;
            end
        endcase
    end

    assign edge_count = cnt_q;

endmodule

// File: tb/tb_acc_threshold.sv
`timescale 1ns / 1ps
// Directed bench for acc_threshold. The edge image is shortened to N words so
// that all runs fit a modest cycle budget; the base address keeps its default.
// A second tiny instance with a 3-bit counter exercises count saturation.
module tb_acc_threshold;

    localparam int unsigned BASE  = 25344;
    localparam int unsigned N     = 1200;
    localparam int unsigned CNT_W = 17;

    logic             clk;
    logic             reset;
    logic [15:0]      addr;
    logic [31:0]      dataR;
    logic [31:0]      dataW;
    logic             en;
    logic             we;
    logic             start;
    logic [7:0]       threshold;
    logic             finish;
    logic [CNT_W-1:0] edge_count;

    logic [15:0]      s_addr;
    logic [31:0]      s_dataW;
    logic             s_en;
    logic             s_we;
    logic             s_start;
    logic             s_finish;
    logic [2:0]       s_count;

    int checks = 0;
    int errors = 0;
    int range_err = 0;

    logic [31:0] mem [0:65535];
    logic        fill_req = 1'b0;
    logic [31:0] fill_val = '0;
    logic        poke_req = 1'b0;
    logic [15:0] poke_addr = '0;
    logic [31:0] poke_val = '0;
    logic        src_req = 1'b0;

    acc_threshold #(
        .BASE_ADDR(BASE),
        .NUM_WORDS(N),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .dataR     (dataR),
        .dataW     (dataW),
        .en        (en),
        .we        (we),
        .start     (start),
        .threshold (threshold),
        .finish    (finish),
        .edge_count(edge_count)
    );

    acc_threshold #(
        .BASE_ADDR(0),
        .NUM_WORDS(3),
        .CNT_W    (3)
    ) sat_dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (s_addr),
        .dataR     (32'h0000_0000),
        .dataW     (s_dataW),
        .en        (s_en),
        .we        (s_we),
        .start     (s_start),
        .threshold (8'h00),
        .finish    (s_finish),
        .edge_count(s_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model plus backdoor fill commands (only issued while the DUT is idle)
    always @(posedge clk) begin
        if (fill_req) begin
            for (int i = 0; i < int'(N); i++) mem[16'(BASE + i)] <= fill_val;
        end else if (poke_req) begin
            mem[poke_addr] <= poke_val;
        end else if (src_req) begin
            for (int i = 0; i < int'(BASE); i++) mem[16'(i)] <= 32'(i) ^ 32'hA5A5_0000;
        end else if (en) begin
            if (we) mem[addr] <= dataW;
            else    dataR     <= mem[addr];
        end
    end

    always @(negedge clk) begin
        if (en === 1'b1 && (addr < 16'(BASE) || addr > 16'(BASE + N - 1))) range_err <= range_err + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cmd_fill(input logic [31:0] v);
        @(negedge clk) fill_val = v; fill_req = 1'b1;
        @(negedge clk) fill_req = 1'b0;
    endtask

    task automatic cmd_poke(input logic [15:0] a, input logic [31:0] v);
        @(negedge clk) poke_addr = a; poke_val = v; poke_req = 1'b1;
        @(negedge clk) poke_req = 1'b0;
    endtask

    // Raise start at a negedge; returns 1 ns after the accepting edge
    task automatic start_run(input logic [7:0] thr, input bit hold);
        @(negedge clk) start = 1'b1; threshold = thr;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    // Counts edges from the accepting edge to the first DONE cycle
    task automatic wait_done(output int n);
        n = 1;
        while (finish !== 1'b1 && n < int'(2 * N + 10)) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic to_idle();
        @(negedge clk) start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic scan(input string tag, input logic [31:0] exp);
        int bad = 0;
        for (int i = 0; i < int'(N); i++) if (mem[16'(BASE + i)] !== exp) bad++;
        check(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        int n;
        int bad;
        reset     = 1'b0;
        start     = 1'b0;
        s_start   = 1'b0;
        threshold = 8'h00;
        #1 reset = 1'b1;
        @(negedge clk);
        @(negedge clk) reset = 1'b0;
        #1;
        check("rst_en", 32'(en), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_dataW", dataW, 32'd0);
        check("rst_finish", 32'(finish), 32'd0);
        check("rst_count", 32'(edge_count), 32'd0);

        @(negedge clk) src_req = 1'b1;
        @(negedge clk) src_req = 1'b0;

        // 1: single-word lane check, first write one cycle after accept
        cmd_fill(32'h0000_0000);
        cmd_poke(16'(BASE), 32'h7F80_00FF);
        start_run(8'h80, 1'b0);
        check("t1_wr_en", 32'(en), 32'd1);
        check("t1_wr_we", 32'(we), 32'd1);
        check("t1_wr_addr", 32'(addr), BASE);
        check("t1_wr_data", dataW, 32'h00FF_00FF);
        wait_done(n);
        check("t1_cycles", 32'(n), 2 * N);
        check("t1_count", 32'(edge_count), 32'd2);
        check("t1_mem0", mem[16'(BASE)], 32'h00FF_00FF);
        check("t1_mem1", mem[16'(BASE + 1)], 32'h0000_0000);
        to_idle();

        // 2: all pixels at threshold
        cmd_fill(32'h0101_0101);
        start_run(8'h01, 1'b0);
        wait_done(n);
        check("t2_cycles", 32'(n), 2 * N);
        check("t2_count", 32'(edge_count), 4 * N);
        to_idle();
        scan("t2_mem", 32'hFFFF_FFFF);

        // 3: all pixels below threshold, start held through DONE
        cmd_fill(32'h0101_0101);
        start_run(8'h02, 1'b1);
        wait_done(n);
        check("t3_cycles", 32'(n), 2 * N);
        check("t3_count", 32'(edge_count), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("t3_hold_finish", 32'(finish), 32'd1);
        check("t3_hold_en", 32'(en), 32'd0);
        to_idle();
        check("t3_idle_finish", 32'(finish), 32'd0);
        scan("t3_mem", 32'h0000_0000);

        // 4: threshold 0 then 255 on the all-FF result
        start_run(8'h00, 1'b1);
        wait_done(n);
        check("t4a_count", 32'(edge_count), 4 * N);
        repeat (3) @(posedge clk);
        #1;
        check("t4a_no_retrig", 32'(en), 32'd0);
        check("t4a_hold_finish", 32'(finish), 32'd1);
        to_idle();
        start_run(8'hFF, 1'b0);
        wait_done(n);
        check("t4b_cycles", 32'(n), 2 * N);
        check("t4b_count", 32'(edge_count), 4 * N);
        to_idle();
        scan("t4_mem", 32'hFFFF_FFFF);

        // 5: reset while reading word 1000
        cmd_fill(32'h0101_0101);
        start_run(8'h01, 1'b0);
        repeat (1999) @(posedge clk);
        @(negedge clk);
        check("t5_pre_addr", 32'(addr), BASE + 1000);
        check("t5_pre_count", 32'(edge_count), 4 * 1000);
        reset = 1'b1;
        #1;
        check("t5_en", 32'(en), 32'd0);
        check("t5_we", 32'(we), 32'd0);
        check("t5_finish", 32'(finish), 32'd0);
        check("t5_count", 32'(edge_count), 32'd0);
        @(negedge clk) reset = 1'b0;
        check("t5_w999", mem[16'(BASE + 999)], 32'hFFFF_FFFF);
        check("t5_w1000", mem[16'(BASE + 1000)], 32'h0101_0101);
        check("t5_wlast", mem[16'(BASE + N - 1)], 32'h0101_0101);
        start_run(8'h01, 1'b0);
        wait_done(n);
        check("t5_rerun_cycles", 32'(n), 2 * N);
        check("t5_rerun_count", 32'(edge_count), 4 * N);
        to_idle();
        scan("t5_mem", 32'hFFFF_FFFF);

        // 6: threshold toggling and start pulses mid-run are ignored
        cmd_fill(32'h80FF_0001);
        start_run(8'h80, 1'b0);
        n = 1;
        while (finish !== 1'b1 && n < int'(2 * N + 10)) begin
            threshold = 8'($urandom);
            start     = (n % 5 == 0);
            @(posedge clk);
            #1;
            n++;
        end
        check("t6_cycles", 32'(n), 2 * N);
        check("t6_count", 32'(edge_count), 2 * N);
        to_idle();
        scan("t6_mem", 32'hFFFF_0000);

        // Saturation: 12 FF pixels into a 3-bit counter
        @(negedge clk) s_start = 1'b1;
        @(posedge clk);
        #1 s_start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("sat_finish", 32'(s_finish), 32'd1);
        check("sat_count", 32'(s_count), 32'd7);

        bad = 0;
        for (int i = 0; i < int'(BASE); i++) if (mem[16'(i)] !== (32'(i) ^ 32'hA5A5_0000)) bad++;
        check("src_intact", 32'(bad), 32'd0);
        check("addr_range", 32'(range_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
